// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and default sizing for the fifo arbiter.
// Rev 1.0
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_DEPTH = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr, wrapping modulo NREQ.
// Rev 1.0
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  int            idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_w = IW'(idx);
      if (!any && req[idx_w]) begin
        any    = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin burst arbiter feeding one fifo, with occupancy tracking.
// Rev 1.0
`default_nettype none

module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       cons_req,
  output logic                       fifo_wen,
  output logic [DW-1:0]              fifo_wdata,
  output logic                       fifo_ren,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic          pick_any;
  logic          not_full;
  logic          not_empty;
  logic          sel_valid;
  logic          sel_last;
  logic          sel_ready;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick),
    .any    (pick_any)
  );

  assign not_full  = (count < DEPTH_C);
  assign not_empty = (count != '0);
  assign busy      = (state == BURST);

  // Only the granted producer is looked at; everyone else sees ready low.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_ready  = 1'b0;
    fifo_wdata = '0;
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        fifo_wdata   = req_data[i*DW +: DW];
        sel_ready    = (state == BURST) && not_full;
        req_ready[i] = sel_ready;
      end
    end
  end

  assign fifo_wen = sel_valid && sel_ready;
  assign fifo_ren = cons_req && not_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any && not_full) begin
            grant_id <= pick;
            state    <= BURST;
          end
        end
        BURST: begin
          // Grant stays locked through valid gaps until the last beat lands.
          if (fifo_wen && sel_last) begin
            state  <= IDLE;
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({fifo_wen, fifo_ren})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      a_no_overflow:  assert (count <= DEPTH_C);
      a_full_blocks:  assert (!(fifo_wen && !not_full));
      a_empty_blocks: assert (!(fifo_ren && !not_empty));
      a_ready_onehot: assert ($onehot0(req_ready));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed stimulus with a write-order scoreboard for fifo_arbiter.
// Rev 1.0
`default_nettype none

module tb_fifo_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BUFSZ = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              cons_req = 1'b0;
  logic              fifo_wen;
  logic [DW-1:0]     fifo_wdata;
  logic              fifo_ren;
  logic [1:0]        grant_id;
  logic              busy;
  logic [4:0]        count;

  fifo_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cons_req   (cons_req),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_ren   (fifo_ren),
    .grant_id   (grant_id),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] gap;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  beat_t pbuf [NREQ][BUFSZ];
  int    head [NREQ];
  int    tail [NREQ];
  exp_t  expq [$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int p, input logic [7:0] d, input logic l, input logic [3:0] g);
    pbuf[p][tail[p]] = '{data: d, last: l, gap: g};
    tail[p]++;
  endtask

  task automatic expect_write(input logic [1:0] id, input logic [7:0] d);
    expq.push_back('{id: id, data: d});
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++)
      if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < tail[i] && pbuf[i][head[i]].gap == 4'd0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = pbuf[i][head[i]].last;
        req_data[i*DW +: DW] = pbuf[i][head[i]].data;
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // Advance one clock: note handshakes before the edge, retire beats after it.
  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) head[i]++;
      else if (head[i] < tail[i] && pbuf[i][head[i]].gap != 4'd0)
        pbuf[i][head[i]].gap = pbuf[i][head[i]].gap - 4'd1;
    end
    drive();
    #1;
  endtask

  task automatic reset_start();
    rst      = 1'b1;
    cons_req = 1'b0;
    flush();
    drive();
    tick();
    tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(all_empty() && !busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_budget", 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && fifo_wen) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got id=%0d data=%02h, required no write", grant_id, fifo_wdata);
      end else begin
        mon_e = expq.pop_front();
        if (grant_id !== mon_e.id || fifo_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write_order: got id=%0d data=%02h, required id=%0d data=%02h",
                   grant_id, fifo_wdata, mon_e.id, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [5];
    exp_g = '{0, 1, 2, 3, 0};

    // Reset with every producer valid, then fairness with single-beat bursts.
    reset_start();
    for (int i = 0; i < NREQ; i++) begin
      push_beat(i, 8'h10 + 8'(i), 1'b1, 4'd0);
      expect_write(2'(i), 8'h10 + 8'(i));
    end
    push_beat(0, 8'h20, 1'b1, 4'd0);
    expect_write(2'd0, 8'h20);
    cons_req = 1'b1;
    drive();
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wen", 32'(fifo_wen), 32'h0);
    check("rst_ren", 32'(fifo_ren), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    cons_req = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_busy", 32'(busy), 32'h1);
      check("rr_grant", 32'(grant_id), 32'(exp_g[k]));
      tick();
      check("rr_bubble", 32'(busy), 32'h0);
    end
    check("rr_count", 32'(count), 32'd5);

    // Full: 17-beat burst from producer 1 with no reads until count hits 16.
    reset_start();
    for (int i = 0; i < 17; i++) begin
      push_beat(1, 8'(i), 1'(i == 16), 4'd0);
      expect_write(2'd1, 8'(i));
    end
    drive();
    rst = 1'b0;
    tick();
    check("full_grant", 32'(grant_id), 32'h1);
    check("full_start_count", 32'(count), 32'h0);
    repeat (16) tick();
    check("full_count", 32'(count), 32'd16);
    check("full_ready", 32'(req_ready), 32'h0);
    check("full_wen", 32'(fifo_wen), 32'h0);
    cons_req = 1'b1;
    #1;
    check("full_ren", 32'(fifo_ren), 32'h1);
    check("full_rd_blocks_wen", 32'(fifo_wen), 32'h0);
    tick();
    cons_req = 1'b0;
    #1;
    check("full_after_read", 32'(count), 32'd15);
    check("full_resume_ready", 32'(req_ready), 32'b0010);
    check("full_resume_wen", 32'(fifo_wen), 32'h1);
    tick();
    check("full_refill", 32'(count), 32'd16);
    check("full_idle", 32'(busy), 32'h0);

    // Empty with simultaneous read and write.
    reset_start();
    push_beat(3, 8'hA1, 1'b0, 4'd0);
    push_beat(3, 8'hA2, 1'b1, 4'd0);
    expect_write(2'd3, 8'hA1);
    expect_write(2'd3, 8'hA2);
    drive();
    cons_req = 1'b1;
    rst = 1'b0;
    tick();
    check("empty_grant", 32'(grant_id), 32'h3);
    check("empty_wen", 32'(fifo_wen), 32'h1);
    check("empty_ren_blocked", 32'(fifo_ren), 32'h0);
    tick();
    check("empty_count1", 32'(count), 32'd1);
    check("empty_ren", 32'(fifo_ren), 32'h1);
    tick();
    check("both_count", 32'(count), 32'd1);
    tick();
    check("drain_count", 32'(count), 32'd0);
    check("drain_ren", 32'(fifo_ren), 32'h0);
    tick();
    check("floor_count", 32'(count), 32'd0);
    cons_req = 1'b0;

    // Burst lock: producer 2 keeps its grant through valid gaps.
    reset_start();
    push_beat(1, 8'h50, 1'b1, 4'd0);
    push_beat(1, 8'h55, 1'b1, 4'd0);
    push_beat(2, 8'h01, 1'b0, 4'd0);
    push_beat(2, 8'h02, 1'b0, 4'd1);
    push_beat(2, 8'h03, 1'b1, 4'd2);
    push_beat(3, 8'h66, 1'b1, 4'd0);
    expect_write(2'd1, 8'h50);
    expect_write(2'd2, 8'h01);
    expect_write(2'd2, 8'h02);
    expect_write(2'd2, 8'h03);
    expect_write(2'd3, 8'h66);
    expect_write(2'd1, 8'h55);
    drive();
    rst = 1'b0;
    repeat (4) tick();
    check("lock_busy", 32'(busy), 32'h1);
    check("lock_grant", 32'(grant_id), 32'h2);
    check("lock_gap_wen", 32'(fifo_wen), 32'h0);
    check("lock_ready", 32'(req_ready), 32'b0100);
    drain(60);
    check("lock_count", 32'(count), 32'd6);

    // Mid-burst reset aborts immediately.
    reset_start();
    push_beat(0, 8'h71, 1'b0, 4'd0);
    push_beat(0, 8'h72, 1'b0, 4'd0);
    push_beat(0, 8'h73, 1'b1, 4'd0);
    expect_write(2'd0, 8'h71);
    drive();
    rst = 1'b0;
    tick();
    tick();
    check("abort_pre_count", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_wen", 32'(fifo_wen), 32'h0);
    flush();
    drive();
    tick();
    rst = 1'b0;
    tick();
    check("post_abort_busy", 32'(busy), 32'h0);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
